// File: rtl/elevator_car_plant.sv
// Plant-side model of an elevator car and its door, answering the controller's
// engine/door commands with floor position, arrival pulses and door status.
module elevator_car_plant #(
  parameter int NUM_FLOORS      = 8,
  parameter int LEVEL_W         = 3,
  parameter int TICKS_PER_FLOOR = 16,
  parameter int DOOR_TICKS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            engine,
  input  logic [1:0]            door,
  input  logic                  obstruct,
  output logic [LEVEL_W-1:0]    level,
  output logic [NUM_FLOORS-1:0] level_onehot,
  output logic                  at_floor,
  output logic                  reached,
  output logic                  door_closed,
  output logic                  door_open,
  output logic                  interlock_err,
  output logic                  limit_err
);

  localparam int PW = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DW = $clog2(DOOR_TICKS + 1);

  localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(NUM_FLOORS - 1);
  localparam logic [PW-1:0]      POS_LAST  = PW'(TICKS_PER_FLOOR - 1);
  localparam logic [DW-1:0]      DPOS_MAX  = DW'(DOOR_TICKS);
  localparam logic [DW-1:0]      DPOS_PRE  = DW'(DOOR_TICKS - 1);
  localparam logic [DW-1:0]      DPOS_ONE  = DW'(1);

  typedef enum logic [1:0] {M_STOP, M_UP, M_DOWN} motion_t;
  typedef enum logic [1:0] {D_CLOSED, D_OPENING, D_OPEN, D_CLOSING} door_t;

  motion_t           mstate;
  door_t             dstate;
  logic [PW-1:0]     pos_cnt;
  logic              launch;
  logic [DW-1:0]     dpos;

  logic              up_cmd, dn_cmd, move_cmd, open_cmd, close_cmd;
  logic              stopped, at_limit, door_busy;
  logic              start_up, start_dn, ilk_req, lim_req, keep_going;
  logic [LEVEL_W-1:0] next_level;

  assign up_cmd    = (engine == 2'd2);
  assign dn_cmd    = (engine == 2'd1);
  assign move_cmd  = up_cmd | dn_cmd;
  assign open_cmd  = (door == 2'd1);
  assign close_cmd = (door == 2'd2);
  assign stopped   = (mstate == M_STOP);

  // An open request in the same cycle as a move request keeps the car parked.
  assign at_limit  = up_cmd ? (level == TOP_LEVEL) : (level == '0);
  assign door_busy = !door_closed || open_cmd;
  assign start_up  = stopped && up_cmd && !door_busy && !at_limit;
  assign start_dn  = stopped && dn_cmd && !door_busy && !at_limit;
  assign lim_req   = stopped && move_cmd && at_limit;
  assign ilk_req   = (stopped && move_cmd && door_busy) || (!stopped && open_cmd);

  assign next_level = (mstate == M_UP) ? level + 1'b1 : level - 1'b1;
  assign keep_going = (mstate == M_UP) ? (up_cmd && next_level != TOP_LEVEL)
                                       : (dn_cmd && next_level != '0);

  // Car motion. The launch cycle models brake release, so the first span
  // takes one cycle longer than a span during continuous travel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstate        <= M_STOP;
      pos_cnt       <= '0;
      launch        <= 1'b0;
      level         <= '0;
      level_onehot  <= NUM_FLOORS'(1);
      at_floor      <= 1'b1;
      reached       <= 1'b0;
      interlock_err <= 1'b0;
      limit_err     <= 1'b0;
    end else begin
      reached       <= 1'b0;
      interlock_err <= ilk_req;
      limit_err     <= lim_req;
      case (mstate)
        M_STOP: begin
          if (start_up || start_dn) begin
            mstate   <= start_up ? M_UP : M_DOWN;
            pos_cnt  <= '0;
            launch   <= 1'b1;
            at_floor <= 1'b0;
          end
        end
        M_UP, M_DOWN: begin
          if (launch) begin
            launch <= 1'b0;
          end else if (pos_cnt == POS_LAST) begin
            level        <= next_level;
            level_onehot <= NUM_FLOORS'(1) << next_level;
            reached      <= 1'b1;
            pos_cnt      <= '0;
            if (!keep_going) begin
              mstate   <= M_STOP;
              at_floor <= 1'b1;
            end
          end else begin
            pos_cnt <= pos_cnt + 1'b1;
          end
        end
        default: mstate <= M_STOP;
      endcase
    end
  end

  // Door mechanics; reversals continue from wherever the door panel is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dstate      <= D_CLOSED;
      dpos        <= '0;
      door_closed <= 1'b1;
      door_open   <= 1'b0;
    end else begin
      case (dstate)
        D_CLOSED: begin
          if (open_cmd && stopped) begin
            dstate      <= D_OPENING;
            door_closed <= 1'b0;
          end
        end
        D_OPENING: begin
          if (close_cmd) begin
            dstate <= D_CLOSING;
          end else if (dpos >= DPOS_PRE) begin
            dpos      <= DPOS_MAX;
            dstate    <= D_OPEN;
            door_open <= 1'b1;
          end else begin
            dpos <= dpos + 1'b1;
          end
        end
        D_OPEN: begin
          if (close_cmd && !obstruct) begin
            dstate    <= D_CLOSING;
            door_open <= 1'b0;
          end
        end
        D_CLOSING: begin
          if (open_cmd || obstruct) begin
            dstate <= D_OPENING;
          end else if (dpos == '0 || dpos == DPOS_ONE) begin
            dpos        <= '0;
            dstate      <= D_CLOSED;
            door_closed <= 1'b1;
          end else begin
            dpos <= dpos - 1'b1;
          end
        end
        default: dstate <= D_CLOSED;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car_plant.sv
// Testbench for elevator_car_plant: directed scenarios plus random traffic,
// all compared against a travel-time/door-position model of the car.
module tb_elevator_car_plant;

  localparam int NF  = 8;
  localparam int LW  = 3;
  localparam int TPF = 16;
  localparam int DT  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    engine = 2'd0;
  logic [1:0]    door = 2'd0;
  logic          obstruct = 1'b0;
  logic [LW-1:0] level;
  logic [NF-1:0] level_onehot;
  logic          at_floor, reached, door_closed, door_open, interlock_err, limit_err;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Model state: car travel as a countdown to the next floor, door as a
  // panel position plus a direction of travel.
  int m_lvl, m_dir, m_ticks, m_dpos, m_ddir;
  bit m_moving, m_reached, m_ilk, m_lim;

  elevator_car_plant #(
    .NUM_FLOORS(NF), .LEVEL_W(LW), .TICKS_PER_FLOOR(TPF), .DOOR_TICKS(DT)
  ) dut (
    .clk(clk), .reset(reset), .engine(engine), .door(door), .obstruct(obstruct),
    .level(level), .level_onehot(level_onehot), .at_floor(at_floor),
    .reached(reached), .door_closed(door_closed), .door_open(door_open),
    .interlock_err(interlock_err), .limit_err(limit_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_lvl = 0; m_dir = 0; m_ticks = 0; m_dpos = 0; m_ddir = 0;
    m_moving = 0; m_reached = 0; m_ilk = 0; m_lim = 0;
  endtask

  task automatic modelStep(input logic [1:0] e, input logic [1:0] d, input logic o);
    bit was_moving;
    bit closed;
    bit lim;
    was_moving = m_moving;
    closed = (m_ddir == 0 && m_dpos == 0);
    m_reached = 0; m_ilk = 0; m_lim = 0;
    if (!was_moving) begin
      if (e == 2'd1 || e == 2'd2) begin
        lim = (e == 2'd2) ? (m_lvl == NF - 1) : (m_lvl == 0);
        if (lim) m_lim = 1;
        if (!closed || d == 2'd1) m_ilk = 1;
        if (closed && d != 2'd1 && !lim) begin
          m_moving = 1;
          m_dir = (e == 2'd2) ? 1 : -1;
          m_ticks = TPF + 1;
        end
      end
    end else begin
      if (d == 2'd1) m_ilk = 1;
      m_ticks--;
      if (m_ticks == 0) begin
        m_lvl += m_dir;
        m_reached = 1;
        if (((m_dir == 1 && e == 2'd2) || (m_dir == -1 && e == 2'd1)) &&
            m_lvl != 0 && m_lvl != NF - 1)
          m_ticks = TPF;
        else
          m_moving = 0;
      end
    end
    if (m_ddir == 0 && m_dpos == 0) begin
      if (d == 2'd1 && !was_moving) m_ddir = 1;
    end else if (m_ddir == 1) begin
      if (d == 2'd2) m_ddir = -1;
      else begin
        m_dpos++;
        if (m_dpos >= DT) begin m_dpos = DT; m_ddir = 0; end
      end
    end else if (m_ddir == 0) begin
      if (d == 2'd2 && !o) m_ddir = -1;
    end else begin
      if (d == 2'd1 || o) m_ddir = 1;
      else begin
        m_dpos--;
        if (m_dpos <= 0) begin m_dpos = 0; m_ddir = 0; end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("level", 32'(level), 32'(m_lvl));
    checkOutput("level_onehot", 32'(level_onehot), 32'(1) << m_lvl);
    checkOutput("at_floor", 32'(at_floor), 32'(!m_moving));
    checkOutput("reached", 32'(reached), 32'(m_reached));
    checkOutput("door_closed", 32'(door_closed), 32'(m_ddir == 0 && m_dpos == 0));
    checkOutput("door_open", 32'(door_open), 32'(m_ddir == 0 && m_dpos == DT));
    checkOutput("interlock_err", 32'(interlock_err), 32'(m_ilk));
    checkOutput("limit_err", 32'(limit_err), 32'(m_lim));
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after.
  task automatic applyStimulus(input logic [1:0] e, input logic [1:0] d, input logic o);
    engine = e; door = d; obstruct = o;
    @(posedge clk);
    modelStep(e, d, o);
    cyc++;
    #1;
    checkAll();
  endtask

  task automatic asyncReset();
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    #1;
    reset = 1'b1;
  endtask

  int first_reached;

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    reset = 1'b1;

    $display("[TB] single floor up");
    applyStimulus(2'd2, 2'd0, 1'b0);
    first_reached = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(2'd0, 2'd0, 1'b0);
      if (reached && first_reached == 0) first_reached = i;
    end
    checkOutput("up1_latency", 32'(first_reached), 32'(TPF + 1));
    checkOutput("up1_level", 32'(level), 32'd1);

    $display("[TB] run 0 to 3");
    asyncReset();
    for (int i = 0; i < 41; i++) applyStimulus(2'd2, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    checkOutput("run_level", 32'(level), 32'd3);

    $display("[TB] travel to top and hit the limit");
    for (int i = 0; i < 70; i++) applyStimulus(2'd2, 2'd0, 1'b0);
    applyStimulus(2'd0, 2'd0, 1'b0);
    applyStimulus(2'd2, 2'd0, 1'b0);
    checkOutput("limit_level", 32'(level), 32'(NF - 1));
    checkOutput("limit_pulse", 32'(limit_err), 32'd1);

    $display("[TB] door cycle with obstruction");
    applyStimulus(2'd0, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    applyStimulus(2'd0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    applyStimulus(2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    checkOutput("reopen_done", 32'(door_open), 32'd1);

    $display("[TB] interlocks");
    applyStimulus(2'd1, 2'd0, 1'b0);
    applyStimulus(2'd0, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'd1, 2'd0, 1'b0);
    applyStimulus(2'd1, 2'd1, 1'b0);
    checkOutput("moving_open_ilk", 32'(interlock_err), 32'd1);
    for (int i = 0; i < 20; i++) applyStimulus(2'd0, 2'd0, 1'b0);

    $display("[TB] async reset mid-span");
    asyncReset();
    for (int i = 0; i < 34; i++) applyStimulus(2'd2, 2'd0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(2'd0, 2'd0, 1'b0);
    checkOutput("pre_reset_level", 32'(level), 32'd2);
    asyncReset();
    checkOutput("post_reset_level", 32'(level), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] e, d;
      logic o;
      int r;
      e = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      d = (r < 6) ? 2'd1 : (r < 14) ? 2'd2 : (r < 16) ? 2'd3 : 2'd0;
      o = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) asyncReset();
      else applyStimulus(e, d, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
